// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared defaults and width helpers for the SAD datapath
package sad_pkg;

  // Ceiling log2, used to size address, partial and result registers.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_N_PAR  = 4;
  localparam int DEF_N_BLK  = 64;
  localparam int DEF_ADDR_W = clog2(DEF_N_BLK / DEF_N_PAR);
  localparam int DEF_SAD_W  = DEF_PIX_W + clog2(DEF_N_BLK);
  localparam int DEF_PART_W = DEF_PIX_W + clog2(DEF_N_PAR);

endpackage

// File: rtl/sad_absdiff_tree.sv
// rtl/sad_absdiff_tree.sv - combinational per-group abs diffs and balanced adder tree
module sad_absdiff_tree
  import sad_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int N_PAR  = DEF_N_PAR,
  parameter int PART_W = PIX_W + clog2(N_PAR)
) (
  input  logic [N_PAR*PIX_W-1:0] a,
  input  logic [N_PAR*PIX_W-1:0] b,
  output logic [PART_W-1:0]      partial
);

  // Unsigned |a-b| per pixel, then pairwise reduction: stride 1, 2, 4, ...
  always_comb begin : tree_p
    logic [PIX_W-1:0]  pa;
    logic [PIX_W-1:0]  pb;
    logic [PART_W-1:0] node [N_PAR];
    pa      = '0;
    pb      = '0;
    partial = '0;
    for (int k = 0; k < N_PAR; k++) begin
      pa      = a[k*PIX_W +: PIX_W];
      pb      = b[k*PIX_W +: PIX_W];
      node[k] = PART_W'((pa >= pb) ? (pa - pb) : (pb - pa));
    end
    for (int s = 1; s < N_PAR; s = s * 2) begin
      for (int i = 0; i + s < N_PAR; i = i + 2 * s) begin
        node[i] = node[i] + node[i + s];
      end
    end
    partial = node[0];
  end

endmodule

// File: rtl/sad_partial_datapath.sv
// rtl/sad_partial_datapath.sv - 3-stage group-parallel SAD datapath driven by the SAD controller
module sad_partial_datapath
  import sad_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int N_PAR = DEF_N_PAR,
  parameter int N_BLK = DEF_N_BLK,
  localparam int ADDR_W = clog2(N_BLK / N_PAR),
  localparam int SAD_W  = PIX_W + clog2(N_BLK)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_sad,
  input  logic                   en_sad,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [N_PAR*PIX_W-1:0] mem_a,
  input  logic [N_PAR*PIX_W-1:0] mem_b,
  output logic                   loaded,
  output logic                   done,
  output logic [SAD_W-1:0]       sad
);

  localparam int N_GRP  = N_BLK / N_PAR;
  localparam int PART_W = PIX_W + clog2(N_PAR);
  localparam int ROW_W  = N_PAR * PIX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_GRP - 1);

  logic [ADDR_W-1:0] addr;
  logic              exhausted;
  logic              accept;
  logic              at_last;
  logic [ROW_W-1:0]  a_q;
  logic [ROW_W-1:0]  b_q;
  logic              v1;
  logic              last1;
  logic [PART_W-1:0] part_d;
  logic [PART_W-1:0] partial;
  logic              v2;
  logic              last2;
  logic [SAD_W-1:0]  acc;
  logic [SAD_W-1:0]  sum_next;

  assign mem_addr = addr;
  assign at_last  = (addr == LAST_ADDR);
  // Once the last group is taken or the result is up, further enables are ignored.
  assign accept   = en_sad & ~exhausted & ~done & ~rst_sad;
  assign loaded   = v1;
  assign sum_next = acc + SAD_W'(partial);

  sad_absdiff_tree #(
    .PIX_W  (PIX_W),
    .N_PAR  (N_PAR),
    .PART_W (PART_W)
  ) u_tree (
    .a       (a_q),
    .b       (b_q),
    .partial (part_d)
  );

  // Stage 1: group address counter, exhausted flag and input capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      exhausted <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      v1        <= 1'b0;
      last1     <= 1'b0;
    end else if (rst_sad) begin
      addr      <= '0;
      exhausted <= 1'b0;
      v1        <= 1'b0;
      last1     <= 1'b0;
    end else begin
      v1    <= accept;
      last1 <= accept & at_last;
      if (accept) begin
        a_q  <= mem_a;
        b_q  <= mem_b;
        addr <= at_last ? '0 : addr + ADDR_W'(1);
        if (at_last) begin
          exhausted <= 1'b1;
        end
      end
    end
  end

  // Stage 2: register the per-group partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      partial <= '0;
      v2      <= 1'b0;
      last2   <= 1'b0;
    end else if (rst_sad) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
    end else begin
      v2    <= v1;
      last2 <= v1 & last1;
      if (v1) begin
        partial <= part_d;
      end
    end
  end

  // Stage 3: accumulate; the last group publishes sad and restarts acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      sad  <= '0;
      done <= 1'b0;
    end else if (rst_sad) begin
      acc  <= '0;
      done <= 1'b0;
    end else if (v2) begin
      if (last2) begin
        sad  <= sum_next;
        done <= 1'b1;
        acc  <= '0;
      end else begin
        acc <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_sad_partial_datapath.sv
// tb/tb_sad_partial_datapath.sv - randomized self-checking bench for sad_partial_datapath
module tb_sad_partial_datapath;
  import sad_pkg::*;

  localparam int NPIX = DEF_N_BLK;
  localparam int NGRP = DEF_N_BLK / DEF_N_PAR;

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              rst_sad;
  logic                              en_sad;
  logic [DEF_ADDR_W-1:0]             mem_addr;
  logic [DEF_N_PAR*DEF_PIX_W-1:0]    mem_a;
  logic [DEF_N_PAR*DEF_PIX_W-1:0]    mem_b;
  logic                              loaded;
  logic                              done;
  logic [DEF_SAD_W-1:0]              sad;

  logic [7:0] pa [NPIX];
  logic [7:0] pb [NPIX];

  int total = 0;
  int bad   = 0;

  int en_q   [$];
  int load_q [$];
  int done_cyc;

  sad_partial_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .rst_sad  (rst_sad),
    .en_sad   (en_sad),
    .mem_addr (mem_addr),
    .mem_a    (mem_a),
    .mem_b    (mem_b),
    .loaded   (loaded),
    .done     (done),
    .sad      (sad)
  );

  always #5 clk = ~clk;

  // Async-read block memories.
  always_comb begin
    mem_a = '0;
    mem_b = '0;
    for (int k = 0; k < DEF_N_PAR; k++) begin
      mem_a[k*8 +: 8] = pa[int'(mem_addr) * DEF_N_PAR + k];
      mem_b[k*8 +: 8] = pb[int'(mem_addr) * DEF_N_PAR + k];
    end
  end

  function automatic int ref_sad();
    int s;
    s = 0;
    for (int p = 0; p < NPIX; p++) begin
      if (int'(pa[p]) >= int'(pb[p])) s += int'(pa[p]) - int'(pb[p]);
      else                            s += int'(pb[p]) - int'(pa[p]);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_block();
    en_sad  = 1'b0;
    rst_sad = 1'b1;
    tick();
    rst_sad = 1'b0;
  endtask

  // Issue 16 enables with 'gap' idle cycles between them; log loaded/done cycles.
  task automatic drive_block(input int gap);
    int c;
    int issued;
    c = 0;
    issued = 0;
    en_q.delete();
    load_q.delete();
    done_cyc = -1;
    while (done_cyc < 0 && c < 300) begin
      en_sad = (issued < NGRP) && (c % (gap + 1) == 0);
      if (en_sad) begin
        en_q.push_back(c);
        issued++;
      end
      tick();
      c++;
      if (loaded) load_q.push_back(c);
      if (done && done_cyc < 0) done_cyc = c;
    end
    en_sad = 1'b0;
  endtask

  task automatic check_block(input string name, input int exp_sad);
    int errs;
    total++;
    if (load_q.size() != NGRP) begin
      bad++;
      $display("FAIL %s loaded_count got=%0d exp=%0d", name, load_q.size(), NGRP);
    end
    errs = 0;
    for (int i = 0; i < load_q.size() && i < en_q.size(); i++)
      if (load_q[i] != en_q[i] + 1) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s loaded_timing got=%0d_late_pulses exp=0", name, errs);
    end
    total++;
    if (en_q.size() != NGRP || done_cyc != en_q[NGRP-1] + 3) begin
      bad++;
      $display("FAIL %s done_cycle got=%0d exp=last_en+3", name, done_cyc);
    end
    total++;
    if (sad !== DEF_SAD_W'(exp_sad)) begin
      bad++;
      $display("FAIL %s sad got=%0d exp=%0d", name, sad, exp_sad);
    end
    total++;
    if (mem_addr !== '0) begin
      bad++;
      $display("FAIL %s addr_wrap got=%0d exp=0", name, mem_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_sad = 1'b0; en_sad = 1'b0;
    for (int p = 0; p < NPIX; p++) begin pa[p] = 8'd0; pb[p] = 8'd0; end
    tick(); tick();
    total++;
    if ({mem_addr, loaded, done, sad} !== '0) begin
      bad++;
      $display("FAIL reset outputs got=%h exp=0", {mem_addr, loaded, done, sad});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_max();
    for (int p = 0; p < NPIX; p++) begin pa[p] = 8'd255; pb[p] = 8'd0; end
    clear_block();
    drive_block(0);
    check_block("max", 16320);
    total++;
    if (load_q.size() > 0 && (load_q[0] != 1 || done_cyc != 18)) begin
      bad++;
      $display("FAIL max abs_timing got=load0 %0d done %0d exp=1 18", load_q[0], done_cyc);
    end
  endtask

  task automatic test_equal();
    for (int p = 0; p < NPIX; p++) begin pa[p] = 8'(p / DEF_N_PAR); pb[p] = pa[p]; end
    clear_block();
    drive_block(0);
    check_block("equal", 0);
  endtask

  task automatic test_gapped();
    for (int p = 0; p < NPIX; p++) begin pa[p] = 8'(p); pb[p] = 8'(p + 1); end
    clear_block();
    drive_block(1);
    check_block("gapped", 64);
  endtask

  task automatic test_rst_sad_mid();
    for (int p = 0; p < NPIX; p++) begin pa[p] = 8'd255; pb[p] = 8'd0; end
    clear_block();
    en_sad = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    clear_block();
    total++;
    if (mem_addr !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_sad_mid cleared got=addr %0d done %0b exp=0 0", mem_addr, done);
    end
    for (int p = 0; p < NPIX; p++) begin
      pb[p] = 8'($urandom_range(1, 254));
      pa[p] = $urandom_range(0, 1) ? pb[p] + 8'd1 : pb[p] - 8'd1;
    end
    drive_block(0);
    check_block("rst_sad_mid", 64);
  endtask

  task automatic test_extra_en_and_rst();
    int nload;
    int exp;
    for (int p = 0; p < NPIX; p++) begin
      pa[p] = 8'($urandom_range(0, 255));
      pb[p] = 8'($urandom_range(0, 255));
    end
    exp = ref_sad();
    clear_block();
    nload = 0;
    en_sad = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (loaded) nload++;
    end
    total++;
    if (nload != NGRP || mem_addr !== '0 || done !== 1'b1 || sad !== DEF_SAD_W'(exp)) begin
      bad++;
      $display("FAIL extra_en got=loads %0d addr %0d done %0b sad %0d exp=16 0 1 %0d",
               nload, mem_addr, done, sad, exp);
    end
    clear_block();
    en_sad = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    en_sad = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_addr, loaded, done, sad} !== '0) begin
      bad++;
      $display("FAIL async_rst got=%h exp=0", {mem_addr, loaded, done, sad});
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_alternating();
    for (int p = 0; p < NPIX; p++) begin
      pa[p] = (p % 2 == 0) ? 8'd10 : 8'd250;
      pb[p] = (p % 2 == 0) ? 8'd250 : 8'd10;
    end
    clear_block();
    drive_block(0);
    check_block("alternating", 15360);
  endtask

  task automatic test_collision();
    logic [DEF_SAD_W-1:0] prev;
    for (int p = 0; p < NPIX; p++) begin
      pa[p] = 8'($urandom_range(0, 255));
      pb[p] = 8'($urandom_range(0, 255));
    end
    clear_block();
    prev = sad;
    for (int c = 0; c < 24; c++) begin
      en_sad  = (c < NGRP);
      rst_sad = (c == 17);
      tick();
    end
    en_sad = 1'b0; rst_sad = 1'b0;
    total++;
    if (done !== 1'b0 || sad !== prev) begin
      bad++;
      $display("FAIL collision got=done %0b sad %0d exp=0 %0d", done, sad, prev);
    end
  endtask

  task automatic test_random();
    int gap;
    for (int it = 0; it < 6; it++) begin
      for (int p = 0; p < NPIX; p++) begin
        pa[p] = 8'($urandom_range(0, 255));
        pb[p] = 8'($urandom_range(0, 255));
      end
      gap = $urandom_range(0, 2);
      clear_block();
      drive_block(gap);
      check_block("random", ref_sad());
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_equal();
    test_gapped();
    test_rst_sad_mid();
    test_extra_en_and_rst();
    test_alternating();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
